// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle FSM and the MIPS datapath.
// master = controller (decodes IR fields, drives enables/selects); slave = datapath.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       ir_wr;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       mem_wr;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] wd_src;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] ext_op;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic       done;

  modport master (
    input  op, funct, zero,
    output ir_wr, pc_wr, pc_src, mem_wr, reg_wr, reg_dst, wd_src,
           alu_src_a, alu_src_b, ext_op, ALUOp, state, done
  );

  modport slave (
    output op, funct, zero,
    input  ir_wr, pc_wr, pc_src, mem_wr, reg_wr, reg_dst, wd_src,
           alu_src_a, alu_src_b, ext_op, ALUOp, state, done
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back.
// Moore outputs from state+IR fields; only BRANCH pc_wr follows zero combinationally.
module mc_ctrl (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADR = 4'd2,  S_MEM_RD = 4'd3,
    S_MEM_WB  = 4'd4,  S_MEM_WR = 4'd5,  S_R_EXE   = 4'd6,  S_R_WB   = 4'd7,
    S_I_EXE   = 4'd8,  S_I_WB   = 4'd9,  S_BRANCH  = 4'd10, S_JUMP   = 4'd11,
    S_JR      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2b;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;

  state_t state_q, state_d;
  logic   r_alu, r_jr, is_mem, is_imm, is_beq, is_jump, dec_ok;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // IR decode; only consumed from DECODE onward, when the IR is stable
  always_comb begin
    r_alu = 1'b0;
    r_jr  = 1'b0;
    if (bus.op == OP_RTYPE) begin
      case (bus.funct)
        F_ADDU, F_SUBU, F_AND, F_OR, F_SRLV, F_SRAV: r_alu = 1'b1;
        F_JR:                                         r_jr  = 1'b1;
        default: ;
      endcase
    end
    is_mem  = (bus.op == OP_LW)  || (bus.op == OP_SW);
    is_imm  = (bus.op == OP_ORI) || (bus.op == OP_LUI);
    is_beq  = (bus.op == OP_BEQ);
    is_jump = (bus.op == OP_J)   || (bus.op == OP_JAL);
    dec_ok  = r_alu || r_jr || is_mem || is_imm || is_beq || is_jump;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if      (is_mem)  state_d = S_MEM_ADR;
        else if (r_alu)   state_d = S_R_EXE;
        else if (is_imm)  state_d = S_I_EXE;
        else if (is_beq)  state_d = S_BRANCH;
        else if (is_jump) state_d = S_JUMP;
        else if (r_jr)    state_d = S_JR;
        else              state_d = S_FETCH;
      end
      S_MEM_ADR: state_d = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_R_EXE:   state_d = S_R_WB;
      S_I_EXE:   state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  assign bus.state = state_q;

  always_comb begin
    bus.ir_wr     = 1'b0;
    bus.pc_wr     = 1'b0;
    bus.pc_src    = 2'd0;
    bus.mem_wr    = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_dst   = 2'd0;
    bus.wd_src    = 2'd0;
    bus.alu_src_a = 2'd0;
    bus.alu_src_b = 3'd0;
    bus.ext_op    = 2'd0;
    bus.ALUOp     = 3'd0;
    bus.done      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.ir_wr     = 1'b1;
          bus.pc_wr     = 1'b1;
          bus.alu_src_b = 3'd1;
        end
        S_DECODE: begin
          bus.alu_src_b = 3'd3;
          bus.ext_op    = 2'd1;
          bus.done      = !dec_ok;
        end
        S_MEM_ADR: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 3'd2;
          bus.ext_op    = 2'd1;
        end
        S_MEM_WB: begin
          bus.reg_wr = 1'b1;
          bus.wd_src = 2'd1;
          bus.done   = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_wr = 1'b1;
          bus.done   = 1'b1;
        end
        S_R_EXE: begin
          bus.alu_src_a = 2'd1;
          case (bus.funct)
            F_SUBU: bus.ALUOp = 3'd1;
            F_AND:  bus.ALUOp = 3'd2;
            F_OR:   bus.ALUOp = 3'd3;
            F_SRLV: begin bus.ALUOp = 3'd4; bus.alu_src_a = 2'd2; bus.alu_src_b = 3'd4; end
            F_SRAV: begin bus.ALUOp = 3'd5; bus.alu_src_a = 2'd2; bus.alu_src_b = 3'd4; end
            default: ;
          endcase
        end
        S_R_WB: begin
          bus.reg_wr  = 1'b1;
          bus.reg_dst = 2'd1;
          bus.done    = 1'b1;
        end
        // lui relies on rs=0 so the OR passes imm<<16 straight through
        S_I_EXE: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 3'd2;
          bus.ALUOp     = 3'd3;
          bus.ext_op    = (bus.op == OP_LUI) ? 2'd2 : 2'd0;
        end
        S_I_WB: begin
          bus.reg_wr = 1'b1;
          bus.done   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 2'd1;
          bus.ALUOp     = 3'd1;
          bus.pc_src    = 2'd1;
          bus.pc_wr     = bus.zero;
          bus.done      = 1'b1;
        end
        S_JUMP: begin
          bus.pc_wr  = 1'b1;
          bus.pc_src = 2'd2;
          bus.done   = 1'b1;
          if (bus.op == OP_JAL) begin
            bus.reg_wr  = 1'b1;
            bus.reg_dst = 2'd2;
            bus.wd_src  = 2'd2;
          end
        end
        S_JR: begin
          bus.pc_wr  = 1'b1;
          bus.pc_src = 2'd3;
          bus.done   = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM that drives the datapath of the MIPS multi-cycle core, including the `ALUOp[2:0]` input of the ALU. It decodes `op` and `funct` from the instruction register and sequences fetch, decode, execute, memory and write-back cycles. It issues every write enable and mux select for the datapath. ALUOp encoding consumed downstream:

- 0 add
- 1 sub
- 2 and
- 3 or
- 4 logical right shift (A>>B)
- 5 arithmetic right shift

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: combinational (ALU result == 0) for the current cycle.
- `ir_wr` out 1: load instruction register.
- `pc_wr` out 1: load PC.
- `pc_src` out 2: PC source. 0 = ALU result, 1 = ALUOut reg, 2 = {PC[31:28], IR[25:0], 2'b00}, 3 = rs reg.
- `mem_wr` out 1: data memory write.
- `reg_wr` out 1: register file write.
- `reg_dst` out 2: write register. 0 = rt, 1 = rd, 2 = $31.
- `wd_src` out 2: write data. 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a` out 2: ALU A input. 0 = PC, 1 = rs reg, 2 = rt reg.
- `alu_src_b` out 3: ALU B input. 0 = rt reg, 1 = const 4, 2 = ext imm, 3 = ext imm<<2, 4 = {27'b0, rs reg[4:0]}.
- `ext_op` out 2: immediate extension. 0 = zero-extend, 1 = sign-extend, 2 = imm<<16.
- `ALUOp` out 3: ALU function, using the encoding above.
- `state` out 4: current state, for debug and verification.
- `done` out 1: high in the last cycle of each instruction.

## Operation
Supported instructions:
- R-type (op 0): addu 0x21, subu 0x23, and 0x24, or 0x25, srlv 0x06, srav 0x07, jr 0x08.
- I-type: ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04.
- J-type: j 0x02, jal 0x03.

Output defaults: every output not listed for a state is 0 (enables low, selects 0, ALUOp 0).

States and asserted outputs:
- FETCH (0): ir_wr=1, pc_wr=1, alu_src_a=0, alu_src_b=1, ALUOp=0, pc_src=0 (PC ← PC+4). Next: DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=3, ext_op=1, ALUOp=0 (branch target → ALUOut). Next by op:
  - lw/sw → MEM_ADR
  - supported R-type except jr → R_EXE
  - ori/lui → I_EXE
  - beq → BRANCH
  - j/jal → JUMP
  - R-type jr → JR
  - any other op/funct → FETCH with done=1 (treated as nop)
- MEM_ADR (2): alu_src_a=1, alu_src_b=2, ext_op=1, ALUOp=0. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD (3): no outputs asserted (memory → MDR). Next: MEM_WB.
- MEM_WB (4): reg_wr=1, reg_dst=0, wd_src=1, done=1. Next: FETCH.
- MEM_WR (5): mem_wr=1, done=1. Next: FETCH.
- R_EXE (6): settings by funct:
  - addu: alu_src_a=1, alu_src_b=0, ALUOp=0
  - subu: alu_src_a=1, alu_src_b=0, ALUOp=1
  - and: alu_src_a=1, alu_src_b=0, ALUOp=2
  - or: alu_src_a=1, alu_src_b=0, ALUOp=3
  - srlv: alu_src_a=2, alu_src_b=4, ALUOp=4
  - srav: alu_src_a=2, alu_src_b=4, ALUOp=5
  - Next: R_WB.
- R_WB (7): reg_wr=1, reg_dst=1, wd_src=0, done=1. Next: FETCH.
- I_EXE (8): alu_src_a=1, alu_src_b=2, ALUOp=3.
  - ori: ext_op=0
  - lui: ext_op=2 and A forced via rs; lui encodes rs=0, so the result is imm<<16
  - Next: I_WB.
- I_WB (9): reg_wr=1, reg_dst=0, wd_src=0, done=1. Next: FETCH.
- BRANCH (10): alu_src_a=1, alu_src_b=0, ALUOp=1, pc_src=1, pc_wr=zero, done=1. Next: FETCH.
- JUMP (11): pc_wr=1, pc_src=2, done=1. For jal additionally reg_wr=1, reg_dst=2, wd_src=2 (PC already holds PC+4). Next: FETCH.
- JR (12): pc_wr=1, pc_src=3, done=1. Next: FETCH.
- Encodings 13–15 are unreachable; if entered, outputs take defaults and next state is FETCH.

## Timing
- While `reset`=1 at a rising edge: state ← FETCH. Outputs are combinational from state and are also forced to defaults while reset is high. No write enable is asserted during reset.
- First FETCH is the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts at the next edge. No further enables are issued; any partial write from an already-completed cycle remains.
- Outputs are Moore (state, op, funct). The one exception is `pc_wr` in BRANCH, which follows `zero` combinationally in that same cycle.
- Cycles per instruction, FETCH through the done cycle inclusive:
  - lw: 5
  - sw, R-type, ori, lui: 4
  - beq, j, jal, jr: 3
  - unsupported: 2
- `done` is high for exactly one cycle per instruction. The next cycle is always FETCH.
- op/funct are sampled from the IR, which is stable from DECODE onward. The FSM must not depend on op/funct during FETCH.

## Test plan
- Reset held 3 cycles, then released: all enables 0 during reset; state=0 on the first cycle after release with ir_wr=1, pc_wr=1, ALUOp=0, alu_src_b=1.
- addu (op 0, funct 0x21): state sequence 0,1,6,7,0. In state 6, ALUOp=0 and alu_src_a=1. In state 7, reg_wr=1, reg_dst=1 and done=1.
- srav (funct 0x07) then lw (op 0x23):
  - srav: R_EXE shows ALUOp=5, alu_src_a=2, alu_src_b=4.
  - lw: sequence 0,1,2,3,4; MEM_WB shows wd_src=1, reg_dst=0.
  - Total 9 cycles.
- beq (op 0x04) twice: zero=1 in BRANCH → pc_wr=1, pc_src=1. zero=0 → pc_wr=0. Both take 3 cycles.
- jal (op 0x03) and jr (op 0, funct 0x08):
  - jal: JUMP with pc_src=2, reg_wr=1, reg_dst=2, wd_src=2.
  - jr: JR with pc_src=3, reg_wr=0.
- Unsupported op 0x3f, then reset asserted in MEM_RD of a following lw:
  - op 0x3f: done=1 in DECODE, next state 0, no writes.
  - Mid-lw reset: next edge state=0 and reg_wr never asserted.
